// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache and the memory controller:
// address/data widths, the default index width and the cache FSM states.
// No ports; imported with "import icache_pkg::*;".
// ---------------------------------------------------------------------------
package icache_pkg;

  localparam int ADDR_RANGE        = 32;
  localparam int DATA_RANGE        = 32;
  localparam int ICACHE_INDEX_BITS = 8;

  // IDLE accepts lookups, MISS waits for a refill that will be returned to
  // fetch, WAIT_DROP waits for a refill whose response fetch no longer wants.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS      = 2'd1,
    ST_WAIT_DROP = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
// Direct-mapped instruction cache, one 32-bit word per line, 1-cycle hit
// latency, blocking single-outstanding refill.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state and outputs
//   flush               fetch redirect; cancels the response owed to fetch
//   valid_from_fetch    fetch request present
//   pc_from_fetch       word-aligned byte address of the request
//   valid_to_fetch      one-cycle pulse, inst_to_fetch valid
//   inst_to_fetch       instruction word
//   valid_to_mem        refill request level to the memory controller
//   addr_to_mem         refill address
//   valid_from_mem      one-cycle pulse, data_from_mem valid
//   data_from_mem       refill word
// ---------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  valid_from_fetch,
  input  logic [ADDR_RANGE-1:0] pc_from_fetch,
  output logic                  valid_to_fetch,
  output logic [DATA_RANGE-1:0] inst_to_fetch,
  output logic                  valid_to_mem,
  output logic [ADDR_RANGE-1:0] addr_to_mem,
  input  logic                  valid_from_mem,
  input  logic [DATA_RANGE-1:0] data_from_mem
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_RANGE - INDEX_BITS - 2;

  icache_state_t r_state;
  icache_state_t w_stateNext;

  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [DATA_RANGE-1:0] r_data [LINES];

  logic                  r_validToFetch;
  logic [DATA_RANGE-1:0] r_instToFetch;
  logic                  r_validToMem;
  logic [ADDR_RANGE-1:0] r_addrToMem;

  logic                  w_validToFetchNext;
  logic [DATA_RANGE-1:0] w_instToFetchNext;
  logic                  w_validToMemNext;
  logic [ADDR_RANGE-1:0] w_addrToMemNext;
  logic                  w_fillEn;

  logic [INDEX_BITS-1:0] w_lookupIndex;
  logic [TAG_BITS-1:0]   w_lookupTag;
  logic                  w_hit;
  logic [INDEX_BITS-1:0] w_fillIndex;
  logic [TAG_BITS-1:0]   w_fillTag;

  assign w_lookupIndex = pc_from_fetch[INDEX_BITS+1:2];
  assign w_lookupTag   = pc_from_fetch[ADDR_RANGE-1:INDEX_BITS+2];
  assign w_hit         = r_valid[w_lookupIndex] && (r_tag[w_lookupIndex] == w_lookupTag);

  // The outstanding miss address doubles as the fill address, so the line
  // being refilled is always the one the request missed on.
  assign w_fillIndex = r_addrToMem[INDEX_BITS+1:2];
  assign w_fillTag   = r_addrToMem[ADDR_RANGE-1:INDEX_BITS+2];

  assign valid_to_fetch = r_validToFetch;
  assign inst_to_fetch  = r_instToFetch;
  assign valid_to_mem   = r_validToMem;
  assign addr_to_mem    = r_addrToMem;

  // Next-state and next-output logic. The fetch pulse defaults low so it
  // lasts exactly one enabled cycle; data and address registers hold.
  // A flush arriving together with the refill data still fills the line
  // but withholds the response, same as a flush earlier in the miss.
  always_comb begin
    w_stateNext        = r_state;
    w_validToFetchNext = 1'b0;
    w_instToFetchNext  = r_instToFetch;
    w_validToMemNext   = r_validToMem;
    w_addrToMemNext    = r_addrToMem;
    w_fillEn           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_from_fetch && !flush) begin
          if (w_hit) begin
            w_validToFetchNext = 1'b1;
            w_instToFetchNext  = r_data[w_lookupIndex];
          end else begin
            w_validToMemNext = 1'b1;
            w_addrToMemNext  = pc_from_fetch;
            w_stateNext      = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        if (valid_from_mem) begin
          w_fillEn         = 1'b1;
          w_validToMemNext = 1'b0;
          w_stateNext      = ST_IDLE;
          if (!flush) begin
            w_validToFetchNext = 1'b1;
            w_instToFetchNext  = data_from_mem;
          end
        end else if (flush) begin
          w_stateNext = ST_WAIT_DROP;
        end
      end
      ST_WAIT_DROP: begin
        if (valid_from_mem) begin
          w_fillEn         = 1'b1;
          w_validToMemNext = 1'b0;
          w_stateNext      = ST_IDLE;
        end
      end
      default: begin
        w_stateNext      = ST_IDLE;
        w_validToMemNext = 1'b0;
      end
    endcase
  end

  // State, output and valid-bit registers. Reset wins over rdy so a reset
  // mid-miss drops the request immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_valid        <= '0;
      r_validToFetch <= 1'b0;
      r_instToFetch  <= '0;
      r_validToMem   <= 1'b0;
      r_addrToMem    <= '0;
    end else if (rdy) begin
      r_state        <= w_stateNext;
      r_validToFetch <= w_validToFetchNext;
      r_instToFetch  <= w_instToFetchNext;
      r_validToMem   <= w_validToMemNext;
      r_addrToMem    <= w_addrToMemNext;
      if (w_fillEn) begin
        r_valid[w_fillIndex] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (rdy && !rst && w_fillEn) begin
      r_tag[w_fillIndex]  <= w_fillTag;
      r_data[w_fillIndex] <= data_from_mem;
    end
  end

endmodule
